// File: rtl/vga_sync_gen.sv
// VGA timing master: pixel-rate divider plus horizontal/vertical counters and sync decode.
// Optional macro VGA_SYNC_DELAY_EN delays display/hsync/vsync by one pixel period.
module vga_sync_gen #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned SYNC_POL = 0
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_tick,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       display,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start
);

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
  localparam int unsigned HS_END  = HS_BEG + H_SYNC - 1;
  localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
  localparam int unsigned VS_END  = VS_BEG + V_SYNC - 1;
  localparam logic        SYNC_ON  = (SYNC_POL != 0);
  localparam logic        SYNC_OFF = ~SYNC_ON;

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] x_q, x_d;
  logic [CNT_W-1:0] y_q, y_d;
  logic             disp_q, disp_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             ls_q, ls_d;
  logic             fs_q, fs_d;

  // Next-state: divider always runs; counters and decodes move only on a pixel tick.
  always_comb begin
    div_d  = div_q;
    tick_d = 1'b0;
    x_d    = x_q;
    y_d    = y_q;
    disp_d = disp_q;
    hs_d   = hs_q;
    vs_d   = vs_q;
    ls_d   = 1'b0;
    fs_d   = 1'b0;

    if (div_q == DIV_W'(CLK_DIV - 1)) begin
      div_d  = '0;
      tick_d = 1'b1;
    end else begin
      div_d = div_q + DIV_W'(1);
    end

    if (tick_q) begin
      if (x_q == CNT_W'(H_TOTAL - 1)) begin
        x_d = '0;
        y_d = (y_q == CNT_W'(V_TOTAL - 1)) ? '0 : y_q + CNT_W'(1);
      end else begin
        x_d = x_q + CNT_W'(1);
      end
      // Decode from the next position so outputs stay coherent with x/y.
      disp_d = (x_d < CNT_W'(H_ACTIVE)) && (y_d < CNT_W'(V_ACTIVE));
      hs_d   = ((x_d >= CNT_W'(HS_BEG)) && (x_d <= CNT_W'(HS_END))) ? SYNC_ON : SYNC_OFF;
      vs_d   = ((y_d >= CNT_W'(VS_BEG)) && (y_d <= CNT_W'(VS_END))) ? SYNC_ON : SYNC_OFF;
      ls_d   = (x_d == '0);
      fs_d   = (x_d == '0) && (y_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= '0;
      tick_q <= 1'b0;
      x_q    <= CNT_W'(H_TOTAL - 1);
      y_q    <= CNT_W'(V_TOTAL - 1);
      disp_q <= 1'b0;
      hs_q   <= SYNC_OFF;
      vs_q   <= SYNC_OFF;
      ls_q   <= 1'b0;
      fs_q   <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
      x_q    <= x_d;
      y_q    <= y_d;
      disp_q <= disp_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      ls_q   <= ls_d;
      fs_q   <= fs_d;
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  logic disp_dly_q;
  logic hs_dly_q;
  logic vs_dly_q;

  // One-pixel lag to line up with pixel generators that register their rgb.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_dly_q <= 1'b0;
      hs_dly_q   <= SYNC_OFF;
      vs_dly_q   <= SYNC_OFF;
    end else if (tick_q) begin
      disp_dly_q <= disp_q;
      hs_dly_q   <= hs_q;
      vs_dly_q   <= vs_q;
    end
  end

  assign display = disp_dly_q;
  assign hsync   = hs_dly_q;
  assign vsync   = vs_dly_q;
`else
  assign display = disp_q;
  assign hsync   = hs_q;
  assign vsync   = vs_q;
`endif

  assign pix_tick    = tick_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: default 640x480 timing plus a tiny CLK_DIV=1, SYNC_POL=1 instance.
module tb_vga_sync_gen;

`ifdef VGA_SYNC_DELAY_EN
  localparam bit DLY = 1'b1;
`else
  localparam bit DLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_d = 1'b1;
  logic rst_s = 1'b1;

  logic       d_pix, d_disp, d_hs, d_vs, d_ls, d_fs;
  logic [9:0] d_x, d_y;
  logic       s_pix, s_disp, s_hs, s_vs, s_ls, s_fs;
  logic [9:0] s_x, s_y;

  int checks = 0;
  int errors = 0;
  int ne     = 0;
  int rel_d  = 0;
  int rel_s  = 0;

  always #5 clk = ~clk;

  vga_sync_gen u_def (
    .clk(clk), .rst(rst_d), .pix_tick(d_pix), .x(d_x), .y(d_y), .display(d_disp),
    .hsync(d_hs), .vsync(d_vs), .line_start(d_ls), .frame_start(d_fs)
  );

  // 16 x 10 total, hsync x in [10,12], vsync y in [6,7], active-high syncs
  vga_sync_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(2), .V_SYNC(2), .V_BP(2), .SYNC_POL(1)
  ) u_sm (
    .clk(clk), .rst(rst_s), .pix_tick(s_pix), .x(s_x), .y(s_y), .display(s_disp),
    .hsync(s_hs), .vsync(s_vs), .line_start(s_ls), .frame_start(s_fs)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      ne++;
      #1;
    end
  endtask

  // Default instance: pixel k (0-based) lands on edge 4k+5 after release.
  task automatic goto_d(input int k);
    step(rel_d + 4 * k + 5 - ne);
  endtask

  // Small instance: pixel k lands on edge k+2 after release.
  task automatic goto_s(input int k);
    step(rel_s + k + 2 - ne);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_hs, n_vs, n_ls, n_fs, n_pix;

    step(2);
    chk("rst_x",     32'(d_x), 799);
    chk("rst_y",     32'(d_y), 524);
    chk("rst_disp",  32'(d_disp), 0);
    chk("rst_hs",    32'(d_hs), 1);
    chk("rst_vs",    32'(d_vs), 1);
    chk("rst_tick",  32'(d_pix), 0);
    chk("rst_ls",    32'(d_ls), 0);
    chk("rst_fs",    32'(d_fs), 0);
    chk("rst_s_hs",  32'(s_hs), 0);
    chk("rst_s_vs",  32'(s_vs), 0);

    // Release default instance; first tick on the 4th edge
    rst_d = 1'b0;
    rel_d = ne;
    step(3);
    chk("tick_pre",  32'(d_pix), 0);
    step(1);
    chk("tick_4th",  32'(d_pix), 1);
    chk("x_hold",    32'(d_x), 799);
    step(1);
    chk("first_x",   32'(d_x), 0);
    chk("first_y",   32'(d_y), 0);
    chk("first_fs",  32'(d_fs), 1);
    chk("first_ls",  32'(d_ls), 1);
    chk("first_disp", 32'(d_disp), DLY ? 0 : 1);
    chk("first_hs",  32'(d_hs), 1);
    chk("first_vs",  32'(d_vs), 1);
    chk("tick_drop", 32'(d_pix), 0);
    step(1);
    chk("fs_pulse",  32'(d_fs), 0);
    chk("x_between", 32'(d_x), 0);

    // Line sweep across the right blanking region
    n_hs = 0;
    for (int k = 600; k < 800; k++) begin
      goto_d(k);
      if (d_hs == 1'b0) n_hs++;
      if (k == 639) chk("disp_639", 32'(d_disp), 1);
      if (k == 640) chk("disp_640", 32'(d_disp), DLY ? 1 : 0);
      if (k == 641) chk("disp_641", 32'(d_disp), 0);
      if (k == 655) chk("hs_655", 32'(d_hs), 1);
      if (k == 656) chk("hs_656", 32'(d_hs), DLY ? 1 : 0);
      if (k == 657) chk("hs_657", 32'(d_hs), 0);
      if (k == 751) chk("hs_751", 32'(d_hs), 0);
      if (k == 752) chk("hs_752", 32'(d_hs), DLY ? 0 : 1);
      if (k == 753) chk("hs_753", 32'(d_hs), 1);
    end
    chk("hs_width", 32'(n_hs), 96);
    chk("x_799", 32'(d_x), 799);
    chk("y_799", 32'(d_y), 0);
    goto_d(800);
    chk("wrap_x",  32'(d_x), 0);
    chk("wrap_y",  32'(d_y), 1);
    chk("wrap_ls", 32'(d_ls), 1);
    chk("wrap_fs", 32'(d_fs), 0);
    chk("wrap_disp", 32'(d_disp), DLY ? 0 : 1);
    step(1);
    chk("ls_pulse", 32'(d_ls), 0);

    // Mid-line, mid-divider reset
    goto_d(1100);
    chk("mid_x", 32'(d_x), 300);
    chk("mid_y", 32'(d_y), 1);
    step(2);
    rst_d = 1'b1;
    step(1);
    chk("mrst_x",    32'(d_x), 799);
    chk("mrst_y",    32'(d_y), 524);
    chk("mrst_disp", 32'(d_disp), 0);
    chk("mrst_hs",   32'(d_hs), 1);
    chk("mrst_vs",   32'(d_vs), 1);
    chk("mrst_tick", 32'(d_pix), 0);
    step(2);
    rst_d = 1'b0;
    rel_d = ne;
    step(3);
    chk("mrel_pre",  32'(d_pix), 0);
    goto_d(0);
    chk("mrel_x",  32'(d_x), 0);
    chk("mrel_y",  32'(d_y), 0);
    chk("mrel_fs", 32'(d_fs), 1);

    // Small instance: CLK_DIV=1, active-high syncs, full frame
    rst_s = 1'b0;
    rel_s = ne;
    step(1);
    chk("s_tick1", 32'(s_pix), 1);
    chk("s_x_hold", 32'(s_x), 15);
    n_hs = 0; n_vs = 0; n_ls = 0; n_fs = 0; n_pix = 0;
    for (int k = 0; k <= 160; k++) begin
      goto_s(k);
      if (s_pix) n_pix++;
      if (s_ls) n_ls++;
      if (s_fs) n_fs++;
      if (s_vs) n_vs++;
      if (k < 16 && s_hs) n_hs++;
      if (k == 0)   chk("s_fs0", 32'(s_fs), 1);
      if (k == 10)  chk("s_hs10", 32'(s_hs), DLY ? 0 : 1);
      if (k == 13)  chk("s_hs13", 32'(s_hs), DLY ? 1 : 0);
      if (k == 16)  chk("s_y16", 32'(s_y), 1);
      if (k == 95)  chk("s_vs95", 32'(s_vs), 0);
      if (k == 96)  chk("s_vs96", 32'(s_vs), DLY ? 0 : 1);
      if (k == 127) chk("s_vs127", 32'(s_vs), 1);
      if (k == 128) chk("s_vs128", 32'(s_vs), DLY ? 1 : 0);
      if (k == 159) chk("s_xy159", 32'({s_y, s_x}), 32'({10'd9, 10'd15}));
      if (k == 160) chk("s_xy160", 32'({s_y, s_x}), 0);
    end
    chk("s_hs_width", 32'(n_hs), 3);
    chk("s_vs_width", 32'(n_vs), 32);
    chk("s_ls_count", 32'(n_ls), 11);
    chk("s_fs_count", 32'(n_fs), 2);
    chk("s_tick_all", 32'(n_pix), 161);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
